// File: rtl/remote_comm_pkg.sv
// Shared definitions for the remote_comm host-side serial bridge:
// default baud divisor, FSM state types and robot response codes.
package remote_comm_pkg;

    // 50 MHz / 19200 baud
    localparam int BAUD_DIV_DEF = 2604;

    // Response bytes the robot sends back
    localparam logic [7:0] RESP_ACK  = 8'hA5;  // calibration done
    localparam logic [7:0] RESP_DONE = 8'h5A;  // move done

    typedef enum logic [1:0] {
        IDLE,
        SEND_HI,
        SEND_LO
    } send_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA
    } rx_state_t;

endpackage

// File: rtl/remote_comm_if.sv
// Host-side command/response bundle of remote_comm.
// master = the bench/host issuing commands, slave = the bridge.
interface remote_comm_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    modport master (output cmd, snd_cmd, input cmd_snt, resp_rdy, resp);
    modport slave  (input cmd, snd_cmd, output cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/remote_comm_uart.sv
// Full-duplex 8N1 transceiver. Bit timing uses down-counters reloaded
// with BAUD_DIV-1 and acted on at terminal count (BAUD_DIV must be >= 8).
// tx_done is combinational in the last clock of the stop bit so a new
// trmt in that same clock starts the next frame with no idle gap.
module remote_comm_uart
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       rx_start
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);

    logic [9:0]    tx_shft;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_busy;

    assign tx_done = tx_busy && (tx_cnt == '0) && (tx_bit == 4'd9);
    // Idle value of the shifter is all ones, so TX is a glitch-free flop output
    assign TX      = tx_shft[0];

    // Transmit shifter: start, 8 data LSB first, stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft <= '1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_busy <= 1'b0;
        end else if (trmt) begin
            tx_shft <= {1'b1, tx_data, 1'b0};
            tx_cnt  <= BIT_LOAD;
            tx_bit  <= '0;
            tx_busy <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == '0) begin
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx_shft <= {1'b1, tx_shft[9:1]};
                    tx_bit  <= tx_bit + 4'd1;
                    tx_cnt  <= BIT_LOAD;
                end
            end else begin
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end

    logic          rx_s1, rx_s2, rx_prev;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shft;
    logic          rx_tc;

    assign rx_start = (rx_state == RX_IDLE) && rx_prev && !rx_s2;
    assign rx_tc    = (rx_cnt == '0);

    // RX synchronizer plus one delayed copy for falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receive FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    // Receive FSM next state; a start bit gone high at mid-bit is a glitch
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_start) rx_next = RX_START;
            RX_START: if (rx_tc) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tc && rx_bit == 4'd8) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Receive datapath: mid-bit sampling, byte load only on a good stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_shft <= '0;
            rx_data <= '0;
            rdy     <= 1'b0;
        end else begin
            rdy <= 1'b0;
            case (rx_state)
                RX_IDLE: rx_cnt <= HALF_LOAD;
                RX_START: begin
                    if (rx_tc) begin
                        rx_cnt <= BIT_LOAD;
                        rx_bit <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tc) begin
                        if (rx_bit == 4'd8) begin
                            if (rx_s2) begin
                                rx_data <= rx_shft;
                                rdy     <= 1'b1;
                            end
                        end else begin
                            rx_shft <= {rx_s2, rx_shft[7:1]};
                            rx_bit  <= rx_bit + 4'd1;
                        end
                        rx_cnt <= BIT_LOAD;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_cnt <= HALF_LOAD;
            endcase
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Host-side serial bridge: sends a 16-bit command as two 8N1 frames
// (high byte first) and reports single-byte robot responses.
// Build option: REMOTE_COMM_STICKY_RDY_EN makes resp_rdy a level that
// holds until the next accepted command or the next start bit; without
// it resp_rdy is a one-clock pulse alongside the resp update.
//
// state   | meaning
// IDLE    | no command in flight; cmd_snt reflects last command
// SEND_HI | shifting out held[15:8]
// SEND_LO | shifting out held[7:0]; cmd_snt set when its stop bit ends
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RX,
    output logic TX,
    remote_comm_if.slave bus
);
    send_state_t state, nxt;
    logic [15:0] held;
    logic        trmt, tx_done, accept;
    logic [7:0]  tx_data, rx_data;
    logic        rdy, rx_start, cmd_snt_q;

    assign accept = (state == IDLE) && bus.snd_cmd;

    remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .TX       (TX),
        .RX       (RX),
        .rx_data  (rx_data),
        .rdy      (rdy),
        .rx_start (rx_start)
    );

    // Send FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Send FSM next state; the high byte comes straight from cmd on accept
    always_comb begin
        nxt     = state;
        trmt    = 1'b0;
        tx_data = held[7:0];
        case (state)
            IDLE: begin
                if (bus.snd_cmd) begin
                    trmt    = 1'b1;
                    tx_data = bus.cmd[15:8];
                    nxt     = SEND_HI;
                end
            end
            SEND_HI: begin
                if (tx_done) begin
                    trmt = 1'b1;
                    nxt  = SEND_LO;
                end
            end
            SEND_LO: if (tx_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Holding register and the cmd_snt level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held      <= '0;
            cmd_snt_q <= 1'b0;
        end else if (accept) begin
            held      <= bus.cmd;
            cmd_snt_q <= 1'b0;
        end else if (state == SEND_LO && tx_done) begin
            cmd_snt_q <= 1'b1;
        end
    end

    assign bus.cmd_snt = cmd_snt_q;
    assign bus.resp    = rx_data;

`ifdef REMOTE_COMM_STICKY_RDY_EN
    logic rdy_lvl;

    // Sticky ready: a new byte wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   rdy_lvl <= 1'b0;
        else if (rdy)                 rdy_lvl <= 1'b1;
        else if (accept || rx_start)  rdy_lvl <= 1'b0;
    end

    assign bus.resp_rdy = rdy_lvl;
`else
    logic unused_rx_start;
    assign unused_rx_start = rx_start;
    assign bus.resp_rdy    = rdy;
`endif

endmodule

// File: tb/tb_remote_comm.sv
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int BD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_line = 1'b1;
    logic tx_line;

    remote_comm_if bus ();

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (rx_line),
        .TX    (tx_line),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // TX line monitor / scoreboard
    logic [7:0] exp_tx[$];
    int         start_cyc[$];
    bit         mon_busy = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    int         tx_frames = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx_line === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt = 0;
                start_cyc.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 8) chk("tx_start_bit", {31'd0, tx_line}, 0);
            if (mon_cnt >= 24 && mon_cnt <= 136 && (mon_cnt % 16) == 8)
                mon_byte = {tx_line, mon_byte[7:1]};
            if (mon_cnt == 152) begin
                mon_busy = 1'b0;
                tx_frames++;
                chk("tx_stop_bit", {31'd0, tx_line}, 1);
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got byte %0h expected none", mon_byte);
                end else begin
                    chk("tx_byte", {24'd0, mon_byte}, {24'd0, exp_tx.pop_front()});
                end
            end
        end
    end

    // Response monitor / scoreboard
    logic [7:0] exp_rx[$];
    logic rdy_q = 1'b0;
    logic snt_q = 1'b0;
    int   rdy_cnt = 0;
    int   snt_rises = 0;

    always @(negedge clk) begin
        if (bus.resp_rdy === 1'b1 && !rdy_q) begin
            rdy_cnt++;
            if (exp_rx.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got resp %0h expected none", bus.resp);
            end else begin
                chk("rx_resp", {24'd0, bus.resp}, {24'd0, exp_rx.pop_front()});
            end
        end
        rdy_q = (bus.resp_rdy === 1'b1);
        if (bus.cmd_snt === 1'b1 && !snt_q) snt_rises++;
        snt_q = (bus.cmd_snt === 1'b1);
    end

    task automatic pulse_send(input logic [15:0] c);
        @(negedge clk);
        bus.cmd = c;
        bus.snd_cmd = 1'b1;
        @(negedge clk);
        bus.snd_cmd = 1'b0;
    endtask

    // Called at the first negedge after acceptance (count 1)
    task automatic wait_snt(output int n);
        n = 1;
        while (bus.cmd_snt !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stopb);
        @(negedge clk);
        rx_line = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (BD) @(negedge clk);
        end
        rx_line = stopb;
        repeat (BD) @(negedge clk);
        rx_line = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } send_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stopb;
        logic [7:0] exp_resp;
        int         exp_rdy;
    } rx_vec_t;

    send_vec_t sv[3];
    rx_vec_t   rv[5];

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0, r0, s0;

        sv[0] = '{16'h4022, 8'h40, 8'h22};
        sv[1] = '{16'hA55A, 8'hA5, 8'h5A};
        sv[2] = '{16'h8001, 8'h80, 8'h01};

        rv[0] = '{RESP_ACK,  1'b1, 8'hA5, 1};
        rv[1] = '{RESP_DONE, 1'b1, 8'h5A, 1};
        rv[2] = '{8'h3C,     1'b0, 8'h5A, 0};
        rv[3] = '{8'h00,     1'b1, 8'h00, 1};
        rv[4] = '{8'hFF,     1'b1, 8'hFF, 1};

        bus.cmd = 16'h0000;
        bus.snd_cmd = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx_line}, 1);
        chk("rst_cmd_snt", {31'd0, bus.cmd_snt}, 0);
        chk("rst_resp_rdy", {31'd0, bus.resp_rdy}, 0);
        chk("rst_resp", {24'd0, bus.resp}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Send vectors
        for (int k = 0; k < 3; k++) begin
            start_cyc.delete();
            f0 = tx_frames;
            exp_tx.push_back(sv[k].hi);
            exp_tx.push_back(sv[k].lo);
            pulse_send(sv[k].cmd);
            chk("cmd_snt_clear", {31'd0, bus.cmd_snt}, 0);
            wait_snt(n);
            chk("cmd_snt_latency_ok", {31'd0, (n <= 20 * BD + 4)}, 1);
            repeat (30) @(negedge clk);
            chk("cmd_snt_hold", {31'd0, bus.cmd_snt}, 1);
            chk("send_frames", tx_frames - f0, 2);
            chk("frame_spacing", (start_cyc.size() == 2) ? start_cyc[1] - start_cyc[0] : -1, 10 * BD);
        end

        // Busy ignore: second request during the high byte is dropped
        f0 = tx_frames;
        s0 = snt_rises;
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
        pulse_send(16'h0000);
        repeat (50) @(negedge clk);
        pulse_send(16'h1234);
        wait_snt(n);
        repeat (200) @(negedge clk);
        chk("busy_frames", tx_frames - f0, 2);
        chk("busy_snt_rises", snt_rises - s0, 1);
        chk("busy_queue_empty", exp_tx.size(), 0);

        // Receive vectors, including a framing error
        for (int k = 0; k < 5; k++) begin
            r0 = rdy_cnt;
            if (rv[k].exp_rdy != 0) exp_rx.push_back(rv[k].exp_resp);
            drive_rx(rv[k].data, rv[k].stopb);
            repeat (4) @(negedge clk);
            chk("rx_resp_value", {24'd0, bus.resp}, {24'd0, rv[k].exp_resp});
            chk("rx_rdy_count", rdy_cnt - r0, rv[k].exp_rdy);
        end

        // Full duplex
        f0 = tx_frames;
        r0 = rdy_cnt;
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hFF);
        exp_rx.push_back(RESP_ACK);
        fork
            pulse_send(16'hFFFF);
            drive_rx(RESP_ACK, 1'b1);
        join
        wait_snt(n);
        repeat (20) @(negedge clk);
        chk("duplex_frames", tx_frames - f0, 2);
        chk("duplex_rdy", rdy_cnt - r0, 1);
        chk("duplex_resp", {24'd0, bus.resp}, {24'd0, RESP_ACK});

        // Glitch shorter than half a bit
        r0 = rdy_cnt;
        @(negedge clk);
        rx_line = 1'b0;
        repeat (BD / 4) @(negedge clk);
        rx_line = 1'b1;
        repeat (12 * BD) @(negedge clk);
        chk("glitch_rdy", rdy_cnt - r0, 0);
        chk("glitch_resp", {24'd0, bus.resp}, {24'd0, RESP_ACK});

        // Reset in the middle of both frames
        f0 = tx_frames;
        r0 = rdy_cnt;
        s0 = snt_rises;
        fork
            pulse_send(16'hF0F0);
            drive_rx(8'h33, 1'b1);
            begin
                repeat (70) @(negedge clk);
                chk("tx_pre_reset", {31'd0, tx_line}, 0);
                rst_n = 1'b0;
                #1;
                chk("tx_reset_immediate", {31'd0, tx_line}, 1);
                chk("reset_resp", {24'd0, bus.resp}, 0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("post_reset_frames", tx_frames - f0, 0);
        chk("post_reset_rdy", rdy_cnt - r0, 0);
        chk("post_reset_snt", snt_rises - s0, 0);
        chk("post_reset_tx", {31'd0, tx_line}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
